// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard front end.
//   - prefix bytes (E0 extended, F0 break) and the list of bytes the decoder drops
//   - held-key struct and the game keycodes consumed by the kid block
//   - receiver state enum
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Keyboard status/acknowledge bytes that never carry a key.
  localparam int         PS2_IGNORE_N = 6;
  localparam logic [7:0] PS2_IGNORE [PS2_IGNORE_N] =
    '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF};

  typedef struct packed {
    logic       ext;   // key was prefixed by E0
    logic [7:0] code;  // low byte of the scan code
  } key_t;

  localparam key_t KC_LEFT  = '{ext: 1'b1, code: 8'h6B};
  localparam key_t KC_RIGHT = '{ext: 1'b1, code: 8'h74};
  localparam key_t KC_SHIFT = '{ext: 1'b0, code: 8'h12};
  localparam key_t KC_R     = '{ext: 1'b0, code: 8'h2D};

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_RECV = 1'b1
  } rx_state_e;

  function automatic logic is_ignored(input logic [7:0] b);
    is_ignored = 1'b0;
    for (int i = 0; i < PS2_IGNORE_N; i++) begin
      if (b == PS2_IGNORE[i]) is_ignored = 1'b1;
    end
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver.
//   Synchronises ps2_clk/ps2_data, debounces ps2_clk, deserialises 11-bit
//   frames (start, 8 data LSB first, odd parity, stop) and aborts a frame that
//   stalls for TIMEOUT cycles.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   ps2_clk, ps2_data   raw asynchronous pad inputs
//   rx_byte[7:0]        last received data byte (valid with rx_done)
//   rx_done             combinational: good frame completed this cycle
//   rx_err              combinational: frame dropped this cycle (framing,
//                       parity or timeout)
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_done,
  output logic       rx_err
);

  localparam int             FW        = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0]  FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [17:0]    TO_LIMIT  = 18'(TIMEOUT);

  logic [1:0]    sync_clk_q, sync_data_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          bit_edge;
  rx_state_e     state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic [17:0]   to_cnt_q, to_cnt_d;
  logic          data_bit;

  assign data_bit = sync_data_q[1];
  assign rx_byte  = shift_q;

  // Filter: count consecutive samples that disagree with the filtered level;
  // the FILTER_LEN-th one flips it. A flip from 1 to 0 is a bit edge.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    filt_d     = filt_q;
    filt_cnt_d = '0;
    bit_edge   = 1'b0;
    if (sync_clk_q[1] != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d   = sync_clk_q[1];
        bit_edge = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    to_cnt_d  = to_cnt_q;
    rx_done   = 1'b0;
    rx_err    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        to_cnt_d = '0;
        if (bit_edge && !data_bit) begin
          state_d   = RX_RECV;
          bit_cnt_d = 4'd1;
        end
      end
      RX_RECV: begin
        if (bit_edge) begin
          to_cnt_d = '0;
          if (bit_cnt_q <= 4'd8) begin
            shift_d   = {data_bit, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (bit_cnt_q == 4'd9) begin
            parity_d  = data_bit;
            bit_cnt_d = 4'd10;
          end else begin
            // Stop edge: back to IDLE so the very next edge may be a start bit.
            state_d   = RX_IDLE;
            bit_cnt_d = 4'd0;
            if (data_bit && (^{shift_q, parity_q})) rx_done = 1'b1;
            else                                    rx_err  = 1'b1;
          end
        end else if (to_cnt_q >= TO_LIMIT) begin
          state_d   = RX_IDLE;
          bit_cnt_d = 4'd0;
          to_cnt_d  = '0;
          rx_err    = 1'b1;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + 18'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: synchroniser and filter reset to 1, the idle PS/2 line level,
      // so leaving reset never looks like a falling clock edge.
      sync_clk_q  <= 2'b11;
      sync_data_q <= 2'b11;
      filt_q      <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= RX_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      parity_q    <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      sync_clk_q  <= {sync_clk_q[0], ps2_clk};
      sync_data_q <= {sync_data_q[0], ps2_data};
      filt_q      <= filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      parity_q    <= parity_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

endmodule

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 keyboard front end feeding the kid block's keycode.
//   Wraps ps2_rx and decodes E0/F0 prefixes into a held-key register that
//   tracks a key from its make code until its matching break code.
// Ports:
//   clk, rst_n          system clock, async active-low reset
//   ps2_clk, ps2_data   raw PS/2 pad inputs
//   keycode[7:0]        low byte of held key, 0 when none
//   keycode_ext         held key was E0-prefixed
//   key_valid           1-cycle pulse when a new non-zero key is loaded
//   frame_err           1-cycle pulse when a frame is dropped
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       keycode_ext,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_done, rx_err;

  key_t held_q, held_d;
  logic ext_pend_q, ext_pend_d;
  logic brk_pend_q, brk_pend_d;
  logic key_valid_q, key_valid_d;
  logic frame_err_q, frame_err_d;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_done  (rx_done),
    .rx_err   (rx_err)
  );

  always_comb begin
    held_d      = held_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    if (rx_err) begin
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end else if (rx_done) begin
      if (rx_byte == PS2_EXT) begin
        ext_pend_d = 1'b1;
      end else if (rx_byte == PS2_BRK) begin
        brk_pend_d = 1'b1;
      end else if (is_ignored(rx_byte)) begin
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end else if (brk_pend_q) begin
        // Only the release of the held key clears it; other releases are
        // ignored.
        if ({ext_pend_q, rx_byte} == held_q) held_d = '0;
        ext_pend_d = 1'b0;
        brk_pend_d = 1'b0;
      end else begin
        // Typematic repeats of the held key leave everything unchanged.
        if ({ext_pend_q, rx_byte} != held_q) begin
          held_d      = '{ext: ext_pend_q, code: rx_byte};
          key_valid_d = 1'b1;
        end
        ext_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q      <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      key_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      held_q      <= held_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      key_valid_q <= key_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign keycode     = held_q.code;
  assign keycode_ext = held_q.ext;
  assign key_valid   = key_valid_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: self-checking bench for ps2_keyboard.
//   PS/2 bit timing and TIMEOUT are scaled down so the run stays short.
module tb_ps2_keyboard;
  import ps2_pkg::*;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 2000;
  localparam int HALF       = 20;   // PS/2 half bit period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] keycode;
  logic       keycode_ext, key_valid, frame_err;

  ps2_keyboard #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keycode     (keycode),
    .keycode_ext (keycode_ext),
    .key_valid   (key_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Monitor: cycle counter, pulse counters and pulse-shape tracking.
  int   cyc = 0;
  int   kv_cnt = 0, fe_cnt = 0, kv_cyc = 0;
  int   fall_cyc = 0;
  logic kv_prev = 1'b0, fe_prev = 1'b0;
  logic pulse_bad = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ((key_valid && frame_err) || (key_valid && kv_prev) || (frame_err && fe_prev))
      pulse_bad = 1'b1;
    if (key_valid) begin
      kv_cnt = kv_cnt + 1;
      kv_cyc = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
    kv_prev = key_valid;
    fe_prev = frame_err;
  end

  // Reference model: held key as {ext, code}, 0 when nothing held;
  // cumulative counts of expected key_valid and frame_err pulses.
  logic [8:0] m_held = '0;
  bit         m_ext = 0, m_brk = 0;
  int         m_kv = 0, m_fe = 0;

  function automatic void model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      m_fe++;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF}) begin
      m_ext = 0;
      m_brk = 0;
    end else if (m_brk) begin
      if ({m_ext, b} == m_held) m_held = '0;
      m_ext = 0;
      m_brk = 0;
    end else begin
      if ({m_ext, b} != m_held) begin
        m_held = {m_ext, b};
        m_kv++;
      end
      m_ext = 0;
    end
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    wait_cycles(HALF);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cycles(HALF);
    ps2_clk  = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par = 0,
                            input bit bad_stop = 0);
    logic par;
    par = (~^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(!bad_stop);
    ps2_data = 1'b1;
    wait_cycles(HALF);
    model_frame(b, !bad_par && !bad_stop);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_cycles(5);
    checks++;
    if ({keycode_ext, keycode, key_valid, frame_err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_state: got ext=%b kc=%h kv=%b fe=%b, want all 0",
               keycode_ext, keycode, key_valid, frame_err);
    end
    rst_n = 1'b1;
    wait_cycles(5);
  endtask

  task automatic test_make_break();
    int kv0, fe0;
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_frame(KC_SHIFT.code);
    checks++;
    if ({keycode_ext, keycode} !== {1'b0, 8'h12} || kv_cnt - kv0 != 1) begin
      errors++;
      $display("FAIL make_shift: got ext=%b kc=%h pulses=%0d, want 0/12/1",
               keycode_ext, keycode, kv_cnt - kv0);
    end
    checks++;
    if (kv_cyc - fall_cyc > 2 + FILTER_LEN + 1 || kv_cyc <= fall_cyc) begin
      errors++;
      $display("FAIL latency: key_valid %0d cycles after stop fall, want 1..%0d",
               kv_cyc - fall_cyc, 2 + FILTER_LEN + 1);
    end
    send_frame(PS2_BRK);
    send_frame(8'h12);
    checks++;
    if ({keycode_ext, keycode} !== 9'd0 || fe_cnt != fe0 || kv_cnt - kv0 != 1) begin
      errors++;
      $display("FAIL break_shift: got kc=%h fe=%0d kv=%0d, want 00/0/1",
               keycode, fe_cnt - fe0, kv_cnt - kv0);
    end
  endtask

  task automatic test_extended();
    int kv0;
    kv0 = kv_cnt;
    send_frame(PS2_EXT);
    send_frame(KC_RIGHT.code);
    checks++;
    if ({keycode_ext, keycode} !== {KC_RIGHT.ext, KC_RIGHT.code}) begin
      errors++;
      $display("FAIL ext_make: got ext=%b kc=%h, want 1/74", keycode_ext, keycode);
    end
    send_frame(PS2_EXT);
    send_frame(PS2_BRK);
    send_frame(8'h74);
    checks++;
    if ({keycode_ext, keycode} !== 9'd0 || kv_cnt - kv0 != 1) begin
      errors++;
      $display("FAIL ext_break: got ext=%b kc=%h kv=%0d, want 0/00/1",
               keycode_ext, keycode, kv_cnt - kv0);
    end
  endtask

  task automatic test_repeat_foreign();
    int kv0;
    kv0 = kv_cnt;
    repeat (3) send_frame(8'h6B);
    send_frame(PS2_BRK);
    send_frame(8'h12);
    checks++;
    if ({keycode_ext, keycode} !== {1'b0, 8'h6B} || kv_cnt - kv0 != 1) begin
      errors++;
      $display("FAIL repeat_foreign: got ext=%b kc=%h kv=%0d, want 0/6b/1",
               keycode_ext, keycode, kv_cnt - kv0);
    end
    send_frame(PS2_BRK);
    send_frame(8'h6B);
    checks++;
    if (keycode !== 8'h00) begin
      errors++;
      $display("FAIL release_6b: got kc=%h, want 00", keycode);
    end
  endtask

  task automatic test_bad_frame();
    int fe0, kv0;
    fe0 = fe_cnt; kv0 = kv_cnt;
    send_frame(8'h12, 1, 0);
    checks++;
    if (fe_cnt - fe0 != 1 || keycode !== 8'h00 || kv_cnt != kv0) begin
      errors++;
      $display("FAIL bad_parity: got fe=%0d kc=%h kv=%0d, want 1/00/0",
               fe_cnt - fe0, keycode, kv_cnt - kv0);
    end
    send_frame(8'h1C, 0, 1);
    checks++;
    if (fe_cnt - fe0 != 2 || keycode !== 8'h00) begin
      errors++;
      $display("FAIL bad_stop: got fe=%0d kc=%h, want 2/00", fe_cnt - fe0, keycode);
    end
    // A dropped frame after F0 must forget the break prefix.
    send_frame(PS2_BRK);
    send_frame(8'h55, 1, 0);
    send_frame(8'h12);
    checks++;
    if (keycode !== 8'h12 || kv_cnt - kv0 != 1) begin
      errors++;
      $display("FAIL err_clears_prefix: got kc=%h kv=%0d, want 12/1",
               keycode, kv_cnt - kv0);
    end
    send_frame(PS2_BRK);
    send_frame(8'h12);
  endtask

  task automatic test_timeout_glitch();
    int fe0, kv0;
    fe0 = fe_cnt; kv0 = kv_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    wait_cycles(TIMEOUT + 500);
    model_frame(8'h00, 0);
    checks++;
    if (fe_cnt - fe0 != 1) begin
      errors++;
      $display("FAIL timeout: got %0d frame_err pulses, want 1", fe_cnt - fe0);
    end
    // Short clock glitches with data low would start a bogus frame if seen.
    ps2_data = 1'b0;
    for (int g = 0; g < 5; g++) begin
      ps2_clk = 1'b0;
      wait_cycles(3);
      ps2_clk = 1'b1;
      wait_cycles(20);
    end
    ps2_data = 1'b1;
    wait_cycles(20);
    send_frame(8'h29);
    checks++;
    if (keycode !== 8'h29 || fe_cnt - fe0 != 1 || kv_cnt - kv0 != 1) begin
      errors++;
      $display("FAIL glitch_then_29: got kc=%h fe=%0d kv=%0d, want 29/1/1",
               keycode, fe_cnt - fe0, kv_cnt - kv0);
    end
  endtask

  task automatic test_reset_midframe();
    int fe0, kv0;
    send_frame(PS2_BRK);
    send_frame(8'h29);
    send_frame(8'h12);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    wait_cycles(5);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({keycode_ext, keycode, key_valid, frame_err} !== 11'd0) begin
      errors++;
      $display("FAIL reset_midframe: got ext=%b kc=%h kv=%b fe=%b, want all 0",
               keycode_ext, keycode, key_valid, frame_err);
    end
    m_held = '0; m_ext = 0; m_brk = 0;
    wait_cycles(5);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    wait_cycles(5);
    rst_n = 1'b1;
    fe0 = fe_cnt; kv0 = kv_cnt;
    wait_cycles(30);
    send_frame(8'h12);
    checks++;
    if (keycode !== 8'h12 || kv_cnt - kv0 != 1 || fe_cnt != fe0) begin
      errors++;
      $display("FAIL after_reset_12: got kc=%h kv=%0d fe=%0d, want 12/1/0",
               keycode, kv_cnt - kv0, fe_cnt - fe0);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [10];
    logic [7:0] b;
    bit bad;
    pool = '{8'h12, 8'h6B, 8'h74, 8'h29, 8'h2D, 8'h1C, 8'hE0, 8'hF0, 8'hF0, 8'hAA};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(4) == 0) b = 8'($urandom);
      else                        b = pool[$urandom_range(9)];
      bad = ($urandom_range(7) == 0);
      if (bad && $urandom_range(1) == 1) send_frame(b, 0, 1);
      else                               send_frame(b, bad, 0);
      checks++;
      if ({keycode_ext, keycode} !== m_held || kv_cnt != m_kv || fe_cnt != m_fe) begin
        errors++;
        $display("FAIL random[%0d] byte %h: got key=%h kv=%0d fe=%0d, want key=%h kv=%0d fe=%0d",
                 n, b, {keycode_ext, keycode}, kv_cnt, fe_cnt, m_held, m_kv, m_fe);
      end
    end
  endtask

  task automatic test_pulse_shape();
    checks++;
    if (pulse_bad !== 1'b0) begin
      errors++;
      $display("FAIL pulse_shape: got overlapping or multi-cycle pulse, want single-cycle exclusive pulses");
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_extended();
    test_repeat_foreign();
    test_bad_frame();
    test_timeout_glitch();
    test_reset_midframe();
    test_random();
    test_pulse_shape();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
